// File: rtl/logic_unit_seq.sv
// Sequential bitwise logic unit: applies one of eight logic ops
// to captured operands SLICE bits per cycle, publishing Z on completion.
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Z,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_z;
  logic             r_zero;
  logic             r_done;

  int               w_lo;
  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic [SLICE-1:0] w_slice;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_lo    = int'(r_cnt) * SLICE;
    w_sa    = r_a[w_lo +: SLICE];
    w_sb    = r_b[w_lo +: SLICE];
    w_slice = '0;
    case (r_op)
      3'b000: w_slice = w_sa & w_sb;
      3'b001: w_slice = w_sa | w_sb;
      3'b010: w_slice = w_sa ^ w_sb;
      3'b011: w_slice = ~(w_sa | w_sb);
      3'b100: w_slice = w_sa & ~w_sb;
      3'b101: w_slice = ~(w_sa & w_sb);
      3'b110: w_slice = w_sa;
      3'b111: w_slice = w_sb;
      default: w_slice = '0;
    endcase
    w_next = r_work;
    w_next[w_lo +: SLICE] = w_slice;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_z     <= '0;
      r_zero  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= OP;
            r_cnt   <= '0;
            r_work  <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_work <= w_next;
          // final slice goes straight to Z so no partial value is ever visible
          if (r_cnt == LAST) begin
            r_z     <= w_next;
            r_zero  <= (w_next == '0);
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Z    = r_z;
  assign ZERO = r_zero;
  assign BUSY = (r_state == S_BUSY);
  assign DONE = r_done;

endmodule

// File: doc/logic_unit_seq.md
LOGIC_UNIT_SEQ -- requirements
Module: logic_unit_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter SLICE, default 8: bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE; N = WIDTH/SLICE.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 START  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 OP  input  3  operation select, captured with START.
REQ-007 A  input  WIDTH  operand A, captured with START.
REQ-008 B  input  WIDTH  operand B, captured with START.
REQ-009 Z  output  WIDTH  registered result of last completed operation.
REQ-010 ZERO  output  1  registered; 1 when last completed Z == 0.
REQ-011 BUSY  output  1  1 while an operation is in progress.
REQ-012 DONE  output  1  one-cycle pulse marking Z/ZERO update.

Function
REQ-013 OP encoding SHALL be: 000 A&B; 001 A|B; 010 A^B; 011 ~(A|B); 100 A&~B; 101 ~(A&B); 110 A; 111 B.
REQ-014 FSM SHALL have two states, IDLE and BUSY; BUSY output = (state == BUSY).
REQ-015 IDLE with START=1 at an edge: capture A, B, OP into internal registers, clear slice counter to 0, clear working result, go BUSY.
REQ-016 IDLE with START=0: remain IDLE; Z, ZERO unchanged.
REQ-017 BUSY, each edge: compute slice [cnt*SLICE +: SLICE] from captured operands and OP, write into working result, cnt increments by 1.
REQ-018 BUSY edge where cnt == N-1: write final slice, load Z with completed result, load ZERO, set DONE=1, go IDLE, cnt wraps to 0.
REQ-019 Latency: START sampled at edge 0 -> slices written at edges 1..N -> Z, ZERO, DONE valid after edge N; BUSY high from after edge 0 until after edge N.
REQ-020 DONE SHALL be high for exactly one cycle per completed operation and 0 otherwise.
REQ-021 START while BUSY SHALL be ignored (no queuing, no restart, no change to captured operands).
REQ-022 Changes on A, B, OP while BUSY SHALL not affect the in-progress result.
REQ-023 Back-to-back: START high in the cycle DONE is high (state IDLE) SHALL be accepted at the next edge; no dead cycle.
REQ-024 Z and ZERO SHALL hold their values until the next operation completes; partial results never appear on Z.
REQ-025 SLICE == WIDTH (N=1): operation completes at edge 1; DONE pulse after edge 1.
REQ-026 Counter width SHALL be ceil(log2(N)), minimum 1 bit; no out-of-range slice index reachable.

Reset
REQ-027 RST=1 at an edge SHALL force state IDLE, cnt 0, Z 0, ZERO 1, BUSY 0, DONE 0, working and captured registers 0.
REQ-028 RST SHALL take priority over START and over BUSY progress; reset mid-operation aborts it, no DONE pulse, Z stays 0.
REQ-029 START held high during RST SHALL not be accepted until the first edge with RST=0.

Verification (WIDTH=32, SLICE=8)
REQ-030 Reset: RST 1 cycle -> Z=0x00000000, ZERO=1, BUSY=0, DONE=0.
REQ-031 AND: A=0xF0F0_1234, B=0xFF00_FF0F, OP=000, START 1 cycle -> BUSY 4 cycles, DONE pulse after 4th edge, Z=0xF000_1204, ZERO=0.
REQ-032 Zero/NOR: A=0xFFFF_FFFF, B=0, OP=011 -> Z=0x00000000, ZERO=1; then OP=101 same operands back-to-back on DONE cycle -> Z=0xFFFF_FFFF, ZERO=0, no idle gap.
REQ-033 Operand stability: start XOR A=0xAAAA_AAAA, B=0x5555_5555, then change A, B, OP and pulse START during BUSY -> Z=0xFFFF_FFFF, exactly one DONE pulse.
REQ-034 Reset mid-op: start ANDN A=0x1234_5678, B=0x0000_FFFF, assert RST at 2nd BUSY edge -> IDLE, Z=0, ZERO=1, no DONE; next run gives Z=0x1234_0000.
REQ-035 All eight OP codes with random operands checked against bitwise model; rerun at SLICE=32 (1-cycle latency) and SLICE=1 (32-cycle latency).
